dc_stage_q: RTL and testbench

Parametrised decode/rename/dispatch stage with an internal decoded-instruction queue between decode and issue.
- Decodes one instruction per cycle, drives rename lookups and allocates ROB/LQ/SQ via `dispatch_valid`.
- Pushes the decoded packet into a QDEPTH-entry circular queue, so issue backpressure is absorbed without stalling fetch.
- Adds finer FU selection (mul/div, falu/fmul/fdiv) and JAL early redirect, qualified by actual acceptance.

---
 rtl/dc_stage_q.sv | 227 ++++++++++++++++++++++
 tb/tb_dc_stage_q.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dc_stage_q.sv
// Decode/rename/dispatch stage feeding a circular decoded-instruction queue.
// Define DC_PERF_EN to build the stall/flush performance counters.
module dc_stage_q #(
  parameter int PREG_W = 7,
  parameter int ROB_W  = 3,
  parameter int LQ_W   = 2,
  parameter int SQ_W   = 2,
  parameter int QDEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      IF_valid,
  input  logic [31:0]               DC_in_pc,
  input  logic [31:0]               DC_in_inst,
  input  logic                      DC_in_jump,
  output logic                      DC_ready,
  input  logic [PREG_W-1:0]         P_rs1,
  input  logic [PREG_W-1:0]         P_rs2,
  input  logic [PREG_W-1:0]         P_rd_new,
  input  logic [PREG_W-1:0]         P_rd_old,
  output logic [5:0]                A_rs1,
  output logic [5:0]                A_rs2,
  output logic [5:0]                A_rd,
  output logic                      allocate_rd,
  input  logic                      rob_ready,
  input  logic [ROB_W-1:0]          DC_rob_idx,
  output logic [31:0]               DC_pc,
  output logic [31:0]               DC_inst,
  output logic [PREG_W-1:0]         DC_P_rd_new,
  output logic [PREG_W-1:0]         DC_P_rd_old,
  output logic                      dispatch_valid,
  input  logic [LQ_W-1:0]           LQ_tail,
  input  logic [SQ_W-1:0]           SQ_tail,
  input  logic                      ld_ready,
  input  logic                      st_ready,
  input  logic                      IS_ready,
  output logic                      DC_valid,
  output logic [31:0]               DC_out_pc,
  output logic [31:0]               DC_out_inst,
  output logic [31:0]               DC_out_imm,
  output logic [4:0]                DC_out_op,
  output logic [2:0]                DC_out_f3,
  output logic [6:0]                DC_out_f7,
  output logic [PREG_W-1:0]         DC_out_P_rs1,
  output logic [PREG_W-1:0]         DC_out_P_rs2,
  output logic [PREG_W-1:0]         DC_out_P_rd,
  output logic [2:0]                DC_out_fu_sel,
  output logic [ROB_W-1:0]          DC_out_rob_idx,
  output logic [LQ_W-1:0]           DC_out_LQ_tail,
  output logic [SQ_W-1:0]           DC_out_SQ_tail,
  output logic                      DC_out_jump,
  input  logic                      mispredict,
  input  logic                      stall,
  output logic                      DC_mispredict,
  output logic [31:0]               DC_redirect_pc,
  output logic [$clog2(QDEPTH):0]   DC_count,
  output logic [31:0]               DC_perf_stall,
  output logic [31:0]               DC_perf_flush
);

  localparam int PW = $clog2(QDEPTH);
  localparam int CW = PW + 1;

  localparam logic [4:0] OP_LOAD  = 5'b00000;
  localparam logic [4:0] OP_FLOAD = 5'b00001;
  localparam logic [4:0] OP_I     = 5'b00100;
  localparam logic [4:0] OP_AUIPC = 5'b00101;
  localparam logic [4:0] OP_S     = 5'b01000;
  localparam logic [4:0] OP_FST   = 5'b01001;
  localparam logic [4:0] OP_R     = 5'b01100;
  localparam logic [4:0] OP_LUI   = 5'b01101;
  localparam logic [4:0] OP_F     = 5'b10100;
  localparam logic [4:0] OP_B     = 5'b11000;
  localparam logic [4:0] OP_JALR  = 5'b11001;
  localparam logic [4:0] OP_JAL   = 5'b11011;
  localparam logic [4:0] OP_CSR   = 5'b11100;

  typedef struct packed {
    logic [31:0]       pc;
    logic [31:0]       inst;
    logic [31:0]       imm;
    logic [4:0]        op;
    logic [2:0]        f3;
    logic [6:0]        f7;
    logic [PREG_W-1:0] prs1;
    logic [PREG_W-1:0] prs2;
    logic [PREG_W-1:0] prd;
    logic [ROB_W-1:0]  rob;
    logic [LQ_W-1:0]   lq;
    logic [SQ_W-1:0]   sq;
    logic [2:0]        fu;
    logic              jump;
  } entry_t;

  logic [31:0] i;
  logic [4:0]  op;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [31:0] imm;
  logic [2:0]  fu;
  logic        is_ld, is_st, is_f, flush, full, push, pop;
  logic [PW-1:0] head, tail;
  logic [CW-1:0] count;
  entry_t mem [QDEPTH];
  entry_t wr, hd;

  assign i  = DC_in_inst;
  assign op = i[6:2];
  assign f3 = i[14:12];
  assign f7 = i[31:25];

  assign is_ld = (op == OP_LOAD) || (op == OP_FLOAD);
  assign is_st = (op == OP_S) || (op == OP_FST);
  assign is_f  = (op == OP_F);

  assign A_rs1 = {is_f, i[19:15]};
  assign A_rs2 = {is_f || op == OP_FST, i[24:20]};
  assign A_rd  = {is_f || op == OP_FLOAD, i[11:7]};
  assign allocate_rd = !is_st && (op != OP_B) && (A_rd != 6'd0);

  always_comb begin
    imm = 32'd0;
    case (op)
      OP_B:     imm = {{20{i[31]}}, i[7], i[30:25], i[11:8], 1'b0};
      OP_JAL:   imm = {{12{i[31]}}, i[19:12], i[20], i[30:21], 1'b0};
      OP_I, OP_LOAD, OP_FLOAD, OP_JALR:
                imm = {{21{i[31]}}, i[30:20]};
      OP_S, OP_FST:
                imm = {{21{i[31]}}, i[30:25], i[11:7]};
      OP_LUI, OP_AUIPC:
                imm = {i[31:12], 12'd0};
      OP_CSR:   imm = {20'd0, i[31:20]};
      default:  imm = 32'd0;
    endcase
  end

  always_comb begin
    fu = 3'd0;
    unique case (1'b1)
      op == OP_R:  fu = (f7 == 7'd1) ? (f3[2] ? 3'd2 : 3'd1) : 3'd0;
      is_f:        fu = (f7[6:2] == 5'b00010) ? 3'd4 :
                        (f7[6:2] == 5'b00011) ? 3'd5 : 3'd3;
      is_ld:       fu = 3'd6;
      is_st:       fu = 3'd7;
      default:     fu = 3'd0;
    endcase
  end

  assign flush = mispredict || stall;
  assign full  = (count == CW'(QDEPTH));
  assign DC_ready = rob_ready && (!is_st || st_ready) && (!is_ld || ld_ready)
                 && !full && !flush;
  assign dispatch_valid = IF_valid && DC_ready;
  assign push = dispatch_valid;
  assign pop  = DC_valid && IS_ready && !flush;

  assign DC_pc       = DC_in_pc;
  assign DC_inst     = DC_in_inst;
  assign DC_P_rd_new = P_rd_new;
  assign DC_P_rd_old = P_rd_old;

  assign DC_mispredict  = IF_valid && (op == OP_JAL) && !DC_in_jump && DC_ready;
  assign DC_redirect_pc = DC_in_pc + imm;

  assign wr = '{pc: DC_in_pc, inst: i, imm: imm, op: op, f3: f3, f7: f7,
                prs1: P_rs1, prs2: P_rs2, prd: P_rd_new, rob: DC_rob_idx,
                lq: LQ_tail, sq: SQ_tail, fu: fu, jump: DC_in_jump};

  always_ff @(posedge clk) begin
    if (push) mem[tail] <= wr;
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + PW'(1);
      if (pop)  head <= head + PW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
    end
  end

  assign DC_valid = (count != '0);
  assign DC_count = count;

  // Stale entries stay hidden so the head reads zero whenever empty.
  assign hd = DC_valid ? mem[head] : '0;

  assign DC_out_pc      = hd.pc;
  assign DC_out_inst    = hd.inst;
  assign DC_out_imm     = hd.imm;
  assign DC_out_op      = hd.op;
  assign DC_out_f3      = hd.f3;
  assign DC_out_f7      = hd.f7;
  assign DC_out_P_rs1   = hd.prs1;
  assign DC_out_P_rs2   = hd.prs2;
  assign DC_out_P_rd    = hd.prd;
  assign DC_out_fu_sel  = hd.fu;
  assign DC_out_rob_idx = hd.rob;
  assign DC_out_LQ_tail = hd.lq;
  assign DC_out_SQ_tail = hd.sq;
  assign DC_out_jump    = hd.jump;

`ifdef DC_PERF_EN
  logic [31:0] perf_stall, perf_flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall <= 32'd0;
      perf_flush <= 32'd0;
    end else begin
      if (IF_valid && !DC_ready) perf_stall <= perf_stall + 32'd1;
      if (flush)                 perf_flush <= perf_flush + 32'd1;
    end
  end

  assign DC_perf_stall = perf_stall;
  assign DC_perf_flush = perf_flush;
`else
  assign DC_perf_stall = 32'd0;
  assign DC_perf_flush = 32'd0;
`endif

endmodule

// File: tb/tb_dc_stage_q.sv
// Scoreboard bench for dc_stage_q: directed decode vectors, queue
// fill/drain, early JAL redirect, flush and performance counters.
module tb_dc_stage_q;

  logic        clk = 0;
  logic        rst;
  logic        IF_valid;
  logic [31:0] DC_in_pc, DC_in_inst;
  logic        DC_in_jump;
  logic        DC_ready;
  logic [6:0]  P_rs1, P_rs2, P_rd_new, P_rd_old;
  logic [5:0]  A_rs1, A_rs2, A_rd;
  logic        allocate_rd;
  logic        rob_ready;
  logic [2:0]  DC_rob_idx;
  logic [31:0] DC_pc, DC_inst;
  logic [6:0]  DC_P_rd_new, DC_P_rd_old;
  logic        dispatch_valid;
  logic [1:0]  LQ_tail, SQ_tail;
  logic        ld_ready, st_ready, IS_ready;
  logic        DC_valid;
  logic [31:0] DC_out_pc, DC_out_inst, DC_out_imm;
  logic [4:0]  DC_out_op;
  logic [2:0]  DC_out_f3;
  logic [6:0]  DC_out_f7;
  logic [6:0]  DC_out_P_rs1, DC_out_P_rs2, DC_out_P_rd;
  logic [2:0]  DC_out_fu_sel;
  logic [2:0]  DC_out_rob_idx;
  logic [1:0]  DC_out_LQ_tail, DC_out_SQ_tail;
  logic        DC_out_jump;
  logic        mispredict, stall;
  logic        DC_mispredict;
  logic [31:0] DC_redirect_pc;
  logic [2:0]  DC_count;
  logic [31:0] DC_perf_stall, DC_perf_flush;

  dc_stage_q dut (
    .clk(clk), .rst(rst), .IF_valid(IF_valid),
    .DC_in_pc(DC_in_pc), .DC_in_inst(DC_in_inst), .DC_in_jump(DC_in_jump),
    .DC_ready(DC_ready),
    .P_rs1(P_rs1), .P_rs2(P_rs2), .P_rd_new(P_rd_new), .P_rd_old(P_rd_old),
    .A_rs1(A_rs1), .A_rs2(A_rs2), .A_rd(A_rd), .allocate_rd(allocate_rd),
    .rob_ready(rob_ready), .DC_rob_idx(DC_rob_idx),
    .DC_pc(DC_pc), .DC_inst(DC_inst),
    .DC_P_rd_new(DC_P_rd_new), .DC_P_rd_old(DC_P_rd_old),
    .dispatch_valid(dispatch_valid),
    .LQ_tail(LQ_tail), .SQ_tail(SQ_tail),
    .ld_ready(ld_ready), .st_ready(st_ready), .IS_ready(IS_ready),
    .DC_valid(DC_valid),
    .DC_out_pc(DC_out_pc), .DC_out_inst(DC_out_inst), .DC_out_imm(DC_out_imm),
    .DC_out_op(DC_out_op), .DC_out_f3(DC_out_f3), .DC_out_f7(DC_out_f7),
    .DC_out_P_rs1(DC_out_P_rs1), .DC_out_P_rs2(DC_out_P_rs2),
    .DC_out_P_rd(DC_out_P_rd), .DC_out_fu_sel(DC_out_fu_sel),
    .DC_out_rob_idx(DC_out_rob_idx),
    .DC_out_LQ_tail(DC_out_LQ_tail), .DC_out_SQ_tail(DC_out_SQ_tail),
    .DC_out_jump(DC_out_jump),
    .mispredict(mispredict), .stall(stall),
    .DC_mispredict(DC_mispredict), .DC_redirect_pc(DC_redirect_pc),
    .DC_count(DC_count),
    .DC_perf_stall(DC_perf_stall), .DC_perf_flush(DC_perf_flush)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc, inst, imm;
    logic [2:0]  fu;
    logic [6:0]  prs1, prs2, prd;
    logic [2:0]  rob;
    logic [1:0]  lq, sq;
    logic        jump;
  } sb_t;

  sb_t sb[$];
  int checks = 0;
  int fails  = 0;
  int seq    = 0;
  logic [31:0] cur_imm;
  logic [2:0]  cur_fu;

  // Directed decode vectors with hand-computed imm / fu_sel / allocate_rd.
  logic [31:0] t_inst [11] = '{32'h027352B3, 32'h027302B3, 32'h103100D3,
                               32'h183100D3, 32'h003100D3, 32'h00312427,
                               32'h00312423, 32'h01012203, 32'h123452B7,
                               32'hFE208EE3, 32'h00000013};
  logic [31:0] t_imm  [11] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h8,
                               32'h8, 32'h10, 32'h12345000, 32'hFFFFFFFC,
                               32'h0};
  logic [2:0]  t_fu   [11] = '{3'd2, 3'd1, 3'd4, 3'd5, 3'd3, 3'd7, 3'd7,
                               3'd6, 3'd0, 3'd0, 3'd0};
  logic        t_al   [11] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0,
                               1'b1, 1'b1, 1'b0, 1'b0};

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [31:0] pc, input logic [31:0] inst,
                       input logic j, input logic [31:0] imm,
                       input logic [2:0] fu);
    DC_in_pc   = pc;
    DC_in_inst = inst;
    DC_in_jump = j;
    cur_imm    = imm;
    cur_fu     = fu;
    P_rs1      = 7'(seq);
    P_rs2      = 7'(seq + 1);
    P_rd_new   = 7'(seq + 2);
    P_rd_old   = 7'(seq + 3);
    DC_rob_idx = 3'(seq);
    LQ_tail    = 2'(seq);
    SQ_tail    = 2'(seq + 1);
    seq++;
  endtask

  task automatic at_neg(input logic acc);
    @(negedge clk);
    chk("dispatch_valid", 32'(dispatch_valid), 32'(acc));
    if (acc)
      sb.push_back('{pc: DC_in_pc, inst: DC_in_inst, imm: cur_imm,
                     fu: cur_fu, prs1: P_rs1, prs2: P_rs2, prd: P_rd_new,
                     rob: DC_rob_idx, lq: LQ_tail, sq: SQ_tail,
                     jump: DC_in_jump});
    if (mispredict || stall) sb.delete();
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare every popped head against the scoreboard.
  always @(negedge clk) begin
    sb_t e;
    if (!rst && DC_valid && IS_ready && !mispredict && !stall) begin
      if (sb.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL pop_empty: got pc %h expected no entry", DC_out_pc);
      end else begin
        e = sb.pop_front();
        chk("out_pc", DC_out_pc, e.pc);
        chk("out_inst", DC_out_inst, e.inst);
        chk("out_imm", DC_out_imm, e.imm);
        chk("out_fu_sel", 32'(DC_out_fu_sel), 32'(e.fu));
        chk("out_fields", {17'd0, DC_out_op, DC_out_f3, DC_out_f7},
            {17'd0, e.inst[6:2], e.inst[14:12], e.inst[31:25]});
        chk("out_pregs", {11'd0, DC_out_P_rs1, DC_out_P_rs2, DC_out_P_rd},
            {11'd0, e.prs1, e.prs2, e.prd});
        chk("out_tags", {24'd0, DC_out_rob_idx, DC_out_LQ_tail,
                         DC_out_SQ_tail, DC_out_jump},
            {24'd0, e.rob, e.lq, e.sq, e.jump});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected end of test");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1; IF_valid = 0; DC_in_jump = 0; rob_ready = 1;
    ld_ready = 1; st_ready = 1; IS_ready = 0; mispredict = 0; stall = 0;
    drive(32'h0, 32'h00000013, 0, 32'h0, 3'd0);
    next(); next();
    @(negedge clk);
    chk("rst_valid", 32'(DC_valid), 32'd0);
    chk("rst_count", 32'(DC_count), 32'd0);
    chk("rst_out_pc", DC_out_pc, 32'd0);
    chk("rst_out_inst", DC_out_inst, 32'd0);
    chk("rst_perf", DC_perf_stall | DC_perf_flush, 32'd0);
    next();
    rst = 0;

    // Fill the queue with IS_ready low.
    IF_valid = 1;
    drive(32'h100, 32'h00500093, 0, 32'h5, 3'd0);
    at_neg(1); chk("fill_ready0", 32'(DC_ready), 32'd1); next();
    drive(32'h104, 32'hFFF08113, 0, 32'hFFFFFFFF, 3'd0);
    at_neg(1); chk("fill_count1", 32'(DC_count), 32'd1); next();
    drive(32'h108, 32'h7FF00193, 0, 32'h7FF, 3'd0);
    at_neg(1); next();
    drive(32'h10C, 32'h00A00213, 0, 32'hA, 3'd0);
    at_neg(1); next();
    drive(32'h110, 32'h00100293, 0, 32'h1, 3'd0);
    at_neg(0);
    chk("full_ready", 32'(DC_ready), 32'd0);
    chk("full_count", 32'(DC_count), 32'd4);
    chk("full_valid", 32'(DC_valid), 32'd1);
    next();

    // Full with a pop: no push this cycle, push resumes after.
    IS_ready = 1;
    at_neg(0); chk("full_pop_ready", 32'(DC_ready), 32'd0); next();
    IS_ready = 0;
    at_neg(1);
    chk("after_pop_count", 32'(DC_count), 32'd3);
    chk("after_pop_ready", 32'(DC_ready), 32'd1);
    next();
    chk("refill_count", 32'(DC_count), 32'd4);

    IF_valid = 0; IS_ready = 1;
    for (int k = 0; k < 4; k++) begin at_neg(0); next(); end
    @(negedge clk);
    chk("drain_count", 32'(DC_count), 32'd0);
    chk("drain_valid", 32'(DC_valid), 32'd0);
    chk("drain_out_pc", DC_out_pc, 32'd0);
    next();

    // Early JAL redirect.
    IF_valid = 1;
    drive(32'h1000, 32'h100000EF, 0, 32'h100, 3'd0);
    at_neg(1);
    chk("jal_mispredict", 32'(DC_mispredict), 32'd1);
    chk("jal_redirect", DC_redirect_pc, 32'h1100);
    next();
    rob_ready = 0;
    drive(32'h1000, 32'h100000EF, 0, 32'h100, 3'd0);
    at_neg(0);
    chk("jal_norob_mispredict", 32'(DC_mispredict), 32'd0);
    chk("jal_norob_ready", 32'(DC_ready), 32'd0);
    next();
    rob_ready = 1;
    drive(32'h2000, 32'h100000EF, 1, 32'h100, 3'd0);
    at_neg(1);
    chk("jal_pred_mispredict", 32'(DC_mispredict), 32'd0);
    next();

    // FU select, immediates and allocate_rd.
    for (int k = 0; k < 11; k++) begin
      drive(32'h3000 + 32'(k * 4), t_inst[k], 0, t_imm[k], t_fu[k]);
      at_neg(1);
      chk("allocate_rd", 32'(allocate_rd), 32'(t_al[k]));
      if (k == 2)
        chk("fmul_arch", {14'd0, A_rs1, A_rs2, A_rd}, {14'd0, 18'h22_8E1});
      if (k == 5)
        chk("fsw_arch", {14'd0, A_rs1, A_rs2, A_rd}, {14'd0, 18'h02_8C8});
      next();
    end

    // Load/store backpressure.
    st_ready = 0;
    drive(32'h4000, 32'h00312423, 0, 32'h8, 3'd7);
    at_neg(0); chk("sw_st_busy", 32'(DC_ready), 32'd0); next();
    st_ready = 1; ld_ready = 0;
    drive(32'h4004, 32'h01012203, 0, 32'h10, 3'd6);
    at_neg(0); chk("lw_ld_busy", 32'(DC_ready), 32'd0); next();
    drive(32'h4008, 32'h00312423, 0, 32'h8, 3'd7);
    at_neg(1); chk("sw_ld_busy", 32'(DC_ready), 32'd1); next();
    ld_ready = 1;

    IF_valid = 0;
    at_neg(0); next(); at_neg(0); next();

    // Flush by mispredict with three entries queued.
    IS_ready = 0; IF_valid = 1;
    for (int k = 0; k < 3; k++) begin
      drive(32'h5000 + 32'(k * 4), 32'h00500093, 0, 32'h5, 3'd0);
      at_neg(1); next();
    end
    mispredict = 1;
    at_neg(0);
    chk("flush_ready", 32'(DC_ready), 32'd0);
    chk("flush_count_before", 32'(DC_count), 32'd3);
    next();
    mispredict = 0; IF_valid = 0;
    at_neg(0);
    chk("flush_count", 32'(DC_count), 32'd0);
    chk("flush_valid", 32'(DC_valid), 32'd0);
    next();

    // Flush by stall.
    IF_valid = 1;
    drive(32'h6000, 32'h00500093, 0, 32'h5, 3'd0);
    at_neg(1); next();
    IF_valid = 0; stall = 1;
    at_neg(0); next();
    stall = 0;
    at_neg(0);
    chk("stall_count", 32'(DC_count), 32'd0);
    next();

    // Performance counters from a fresh reset.
    rst = 1; next(); rst = 0;
    st_ready = 0; IF_valid = 1;
    drive(32'h7000, 32'h00312423, 0, 32'h8, 3'd7);
    for (int k = 0; k < 5; k++) begin at_neg(0); next(); end
    IF_valid = 0; st_ready = 1; mispredict = 1;
    at_neg(0); next();
    mispredict = 0; stall = 1;
    at_neg(0); next();
    stall = 0;
    @(negedge clk);
`ifdef DC_PERF_EN
    chk("perf_stall", DC_perf_stall, 32'd5);
    chk("perf_flush", DC_perf_flush, 32'd2);
`else
    chk("perf_stall", DC_perf_stall, 32'd0);
    chk("perf_flush", DC_perf_flush, 32'd0);
`endif
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule
